uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 16: clocks per serial bit, legal range 2..65535.
REQ-002 SHALL provide port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port data  input  8  byte to transmit, sampled when a write is accepted.
REQ-005 SHALL provide port wr  input  1  write strobe, one byte per accepted cycle.
REQ-006 SHALL provide port ce  input  1  chip enable; wr is ignored while ce=0.
REQ-007 SHALL provide port rdy  output  1  high when a write will be accepted this cycle.
REQ-008 SHALL provide port busy  output  1  high while a frame is on the line (START..STOP).
REQ-009 SHALL provide port tdc  output  1  transmit-done pulse, one clk wide, at the end of each frame.
REQ-010 SHALL provide port Txd  output  1  serial line, idle high.

Function
REQ-011 SHALL accept a write in a cycle where wr=1, ce=1 and rdy=1; in all other cycles wr SHALL have no effect.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (only with the macro) and STOP; each bit state SHALL last exactly BAUD_DIV clocks.
REQ-013 Frame SHALL be: start bit 0, data[0]..data[7] LSB first, optional parity, one stop bit 1.
REQ-014 An accepted write in IDLE SHALL load the shift register directly; START is entered and Txd=0 from the next clock; the holding register stays empty and rdy stays 1.
REQ-015 An accepted write while busy=1 SHALL store the byte in a one-entry holding register; rdy SHALL be 0 from the next cycle until that entry is drained.
REQ-016 On the last clock of STOP: if the holding register is full, its byte SHALL load into the shifter, the entry SHALL clear, and START SHALL begin on the next clock (no idle bit); otherwise the FSM SHALL return to IDLE.
REQ-017 A write accepted on the last STOP clock with the holding register empty SHALL behave as in REQ-016 (back-to-back frame, no idle gap).
REQ-018 tdc SHALL pulse high for one clock on the cycle after the last STOP clock, once per frame, including back-to-back frames.
REQ-019 busy SHALL be 1 from the first START clock through the last STOP clock; it SHALL remain 1 continuously across back-to-back frames.
REQ-020 Txd SHALL be registered; it SHALL be 1 in IDLE and in STOP.
REQ-021 ce falling mid-frame SHALL NOT abort or stretch the frame in progress.
REQ-022 The bit counter SHALL be ceil(log2(BAUD_DIV)) bits wide and SHALL wrap to 0 at BAUD_DIV-1; the data-bit index SHALL count 0..7.

Reset
REQ-023 While rst=1 at a clock edge, the FSM SHALL go to IDLE, with Txd=1, busy=0, rdy=1, tdc=0, the holding register empty, and all counters at 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame, return Txd high on the next clock, and discard any held byte; no tdc SHALL be generated.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and transmit the even-parity bit (XOR of the 8 data bits); a frame is 11*BAUD_DIV clocks.
REQ-026 Without UART_TX_PARITY_EN, no PARITY state or logic SHALL exist; DATA goes directly to STOP, and a frame is 10*BAUD_DIV clocks.

Verification (BAUD_DIV=4)
REQ-027 Single byte: wr with data=8'hA5 in IDLE -> Txd reads 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks wide starting the next clock; tdc pulses once 40 clocks after START begins.
REQ-028 Back-to-back: write 8'h55 then 8'h0F during that frame -> rdy=0 until the second frame starts, no idle clock between frames, busy stays high for 80 clocks, and tdc pulses twice.
REQ-029 Overrun: a third write while the holding register is full -> ignored; only two frames are sent.
REQ-030 Gating: wr=1 with ce=0 in IDLE -> Txd stays 1, busy stays 0; ce dropped mid-frame -> the frame completes normally.
REQ-031 Reset mid-frame: rst at DATA bit 3 -> next clock Txd=1, busy=0, rdy=1; no tdc.
REQ-032 Parity build: data=8'h07 -> parity bit 1; data=8'h03 -> parity bit 0; frame is 44 clocks.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, one stop bit, one-entry holding register.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module uart_tx #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       wr,
    input  logic       ce,
    output logic       rdy,
    output logic       busy,
    output logic       tdc,
    output logic       Txd
);

    localparam int CW = $clog2(BAUD_DIV);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      hold_q, hold_d;
    logic            hfull_q, hfull_d;
    logic            tdc_q, tdc_d;
    logic            txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic accept;
    logic bit_end;

    assign rdy     = ~hfull_q;
    assign busy    = (state_q != IDLE);
    assign tdc     = tdc_q;
    assign Txd     = txd_q;
    assign accept  = wr & ce & ~hfull_q;
    assign bit_end = (cnt_q == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            hold_q  <= '0;
            hfull_q <= 1'b0;
            tdc_q   <= 1'b0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            hfull_q <= hfull_d;
            tdc_q   <= tdc_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Txd is computed for the state being entered so the registered line lines up with state_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        hfull_d = hfull_q;
        tdc_d   = 1'b0;
        txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sh_d    = data;
                    txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    txd_d   = sh_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        txd_d = sh_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tdc_d = 1'b1;
                    if (hfull_q) begin
                        state_d = START;
                        cnt_d   = '0;
                        idx_d   = '0;
                        sh_d    = hold_q;
                        hfull_d = 1'b0;
                        txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^hold_q;
`endif
                    end else if (accept) begin
                        state_d = START;
                        cnt_d   = '0;
                        idx_d   = '0;
                        sh_d    = data;
                        txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^data;
`endif
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // A write mid-frame parks in the holding register; the last STOP clock loads directly instead.
        if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_end)) begin
            hold_d  = data;
            hfull_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (BAUD_DIV=4): directed scenarios plus random traffic,
// compared every cycle against a frame-timeline reference model.
module tb_uart_tx;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BD;

    logic       clk = 1'b0;
    logic       rst, wr, ce;
    logic [7:0] data;
    logic       rdy, busy, tdc, Txd;

    uart_tx #(.BAUD_DIV(BD)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .wr   (wr),
        .ce   (ce),
        .rdy  (rdy),
        .busy (busy),
        .tdc  (tdc),
        .Txd  (Txd)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int tdc_seen = 0;
    int busy_seen = 0;

    // Reference model: position within the current frame plus a one-deep pending byte.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_cur    = '0;
    bit         m_hv     = 1'b0;
    logic [7:0] m_hold   = '0;
    bit         m_tdc    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_start(input logic [7:0] b);
        m_active = 1'b1;
        m_t      = 0;
        m_cur    = b;
    endtask

    task automatic step(input logic r, input logic w, input logic c, input logic [7:0] d);
        bit acc, last;
        @(negedge clk);
        check_eq("txd",  {31'b0, Txd},  {31'b0, (m_active ? exp_bit(m_cur, m_t / BD) : 1'b1)});
        check_eq("busy", {31'b0, busy}, {31'b0, m_active});
        check_eq("rdy",  {31'b0, rdy},  {31'b0, ~m_hv});
        check_eq("tdc",  {31'b0, tdc},  {31'b0, m_tdc});
        if (tdc)  tdc_seen++;
        if (busy) busy_seen++;
        rst = r; wr = w; ce = c; data = d;
        @(posedge clk);
        if (r) begin
            m_active = 1'b0; m_t = 0; m_hv = 1'b0; m_tdc = 1'b0;
        end else begin
            acc   = w && c && !m_hv;
            last  = m_active && (m_t == FRAME - 1);
            m_tdc = last;
            if (!m_active) begin
                if (acc) model_start(d);
            end else if (last) begin
                if (m_hv) begin
                    model_start(m_hold);
                    m_hv = 1'b0;
                end else if (acc) begin
                    model_start(d);
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_t++;
                if (acc) begin
                    m_hold = d;
                    m_hv   = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; ce = 1'b0; data = '0;
        repeat (2) @(posedge clk);

        // Reset state, then a single byte
        step(0, 0, 0, 8'h00);
        tdc_seen = 0;
        step(0, 1, 1, 8'hA5);
        repeat (FRAME + 5) step(0, 0, 1, 8'h00);
        check_eq("a5_tdc_count", tdc_seen, 1);

        // Back-to-back with an overrun write while the holding register is full
        tdc_seen = 0; busy_seen = 0;
        step(0, 1, 1, 8'h55);
        repeat (10) step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h0F);
        repeat (5) step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'hFF);
        repeat (2 * FRAME + 10) step(0, 0, 1, 8'h00);
        check_eq("b2b_tdc_count", tdc_seen, 2);
        check_eq("b2b_busy_cycles", busy_seen, 2 * FRAME);

        // Gating: wr without ce, then ce dropped mid-frame
        busy_seen = 0;
        repeat (3) step(0, 1, 0, 8'h3C);
        check_eq("gated_busy_cycles", busy_seen, 0);
        tdc_seen = 0;
        step(0, 1, 1, 8'h96);
        repeat (12) step(0, 0, 0, 8'h00);
        repeat (FRAME) step(0, 1, 0, 8'h11);
        check_eq("ce_drop_tdc_count", tdc_seen, 1);

        // Parity-relevant bytes
        step(0, 1, 1, 8'h07);
        repeat (3) step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h03);
        repeat (2 * FRAME + 4) step(0, 0, 1, 8'h00);

        // Reset at DATA bit 3 with a byte held
        step(0, 1, 1, 8'hC3);
        repeat (5) step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h5A);
        repeat (11) step(0, 0, 1, 8'h00);
        tdc_seen = 0; busy_seen = 0;
        step(1, 0, 1, 8'h00);
        repeat (FRAME + 4) step(0, 0, 1, 8'h00);
        check_eq("rst_tdc_count", tdc_seen, 0);
        check_eq("rst_busy_cycles", busy_seen, 1);

        // Random traffic: sparse writes, then dense writes to hit last-STOP accepts
        repeat (3000) step($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 7) != 0, 8'($urandom()));
        repeat (3000) step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 0,
                           $urandom_range(0, 7) != 0, 8'($urandom()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
